// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - frame-synchronous Pong controller (ball, paddles, score FSM)
// Optional ball speed-up on paddle hits: define PONG_CTRL_SPEEDUP_EN.
module pong_game_ctrl #(
    parameter int H_VISIBLE    = 640,
    parameter int V_VISIBLE    = 480,
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_X_L   = 16,
    parameter int PADDLE_X_R   = 616,
    parameter int PADDLE_STEP  = 4,
    parameter int BALL_STEP    = 2,
    parameter int MAX_STEP     = 6,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 7
) (
    input  logic       clkIn,
    input  logic       rstIn,
    input  logic       vSyncIn,
    input  logic       startIn,
    input  logic       lUpIn,
    input  logic       lDnIn,
    input  logic       rUpIn,
    input  logic       rDnIn,
    output logic       vgaEnableOut,
    output logic [9:0] ballXOut,
    output logic [9:0] ballYOut,
    output logic [9:0] lPadYOut,
    output logic [9:0] rPadYOut,
    output logic [3:0] lScoreOut,
    output logic [3:0] rScoreOut,
    output logic [2:0] stateOut,
    output logic [1:0] winnerOut
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SERVE    = 3'd1,
        PLAY     = 3'd2,
        POINT    = 3'd3,
        GAMEOVER = 3'd4
    } state_t;

    localparam logic [9:0]  X_MAX      = 10'(H_VISIBLE - BALL_SIZE);
    localparam logic [9:0]  Y_MAX      = 10'(V_VISIBLE - BALL_SIZE);
    localparam logic [9:0]  PAD_MAX    = 10'(V_VISIBLE - PADDLE_H);
    localparam logic [9:0]  X_CTR      = 10'((H_VISIBLE - BALL_SIZE) / 2);
    localparam logic [9:0]  Y_CTR      = 10'((V_VISIBLE - BALL_SIZE) / 2);
    localparam logic [9:0]  PAD_CTR    = 10'((V_VISIBLE - PADDLE_H) / 2);
    localparam logic [9:0]  L_EDGE     = 10'(PADDLE_X_L + PADDLE_W);
    localparam logic [9:0]  R_EDGE     = 10'(PADDLE_X_R - BALL_SIZE);
    localparam logic [9:0]  BALL_H     = 10'(BALL_SIZE);
    localparam logic [9:0]  PAD_H      = 10'(PADDLE_H);
    localparam logic [9:0]  PAD_STEP   = 10'(PADDLE_STEP);
    localparam logic [9:0]  STEP_INIT  = 10'(BALL_STEP);
    localparam logic [9:0]  STEP_CAP   = 10'((MAX_STEP > BALL_STEP) ? MAX_STEP : BALL_STEP);
    localparam logic [15:0] SERVE_LAST = 16'(SERVE_FRAMES - 1);
    localparam logic [3:0]  WIN        = 4'(WIN_SCORE);
`ifdef PONG_CTRL_SPEEDUP_EN
    localparam logic [9:0]  STEP_INC   = 10'd1;
`else
    localparam logic [9:0]  STEP_INC   = 10'd0;
`endif

    state_t      state, state_n;
    logic [9:0]  ball_x, ball_x_n, ball_y, ball_y_n, lpad, lpad_n, rpad, rpad_n;
    logic [9:0]  step, step_n, step_hit, y_mv;
    logic [15:0] serve_cnt, serve_cnt_n;
    logic [3:0]  lscore, lscore_n, rscore, rscore_n, score_cur, score_inc;
    logic [1:0]  winner, winner_n;
    logic        dx, dx_n, dy, dy_n, dy_mv, left_scored, left_scored_n;
    logic        vs_q, start_q, vga_en, tick, start_edge;
    logic        l_hit, r_hit, l_miss, r_miss;

    function automatic logic [9:0] pad_move(input logic [9:0] y, input logic up, input logic dn);
        pad_move = y;
        if (up && !dn)
            pad_move = (y < PAD_STEP) ? 10'd0 : y - PAD_STEP;
        else if (dn && !up)
            pad_move = (y + PAD_STEP > PAD_MAX) ? PAD_MAX : y + PAD_STEP;
    endfunction

    assign tick       = vSyncIn & ~vs_q;
    assign start_edge = startIn & ~start_q;

    // Hit tests use the pre-tick ball and paddle positions; dx=1 means moving right.
    assign l_hit  = !dx && (ball_x >= L_EDGE) && (ball_x <= L_EDGE + step)
                    && (ball_y + BALL_H > lpad) && (ball_y < lpad + PAD_H);
    assign r_hit  = dx && (ball_x <= R_EDGE) && (ball_x + step >= R_EDGE)
                    && (ball_y + BALL_H > rpad) && (ball_y < rpad + PAD_H);
    assign l_miss = !dx && (ball_x < step) && !l_hit;
    assign r_miss = dx && (ball_x + step > X_MAX) && !r_hit;

    assign step_hit  = (step + STEP_INC > STEP_CAP) ? STEP_CAP : step + STEP_INC;
    assign score_cur = left_scored ? lscore : rscore;
    assign score_inc = (score_cur == 4'hF) ? 4'hF : score_cur + 4'd1;

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            state       <= IDLE;
            vga_en      <= 1'b0;
            ball_x      <= X_CTR;
            ball_y      <= Y_CTR;
            lpad        <= PAD_CTR;
            rpad        <= PAD_CTR;
            lscore      <= 4'd0;
            rscore      <= 4'd0;
            winner      <= 2'd0;
            dx          <= 1'b1;
            dy          <= 1'b1;
            step        <= STEP_INIT;
            serve_cnt   <= 16'd0;
            left_scored <= 1'b0;
            vs_q        <= 1'b1;
            start_q     <= 1'b1;
        end else begin
            state       <= state_n;
            vga_en      <= 1'b1;
            ball_x      <= ball_x_n;
            ball_y      <= ball_y_n;
            lpad        <= lpad_n;
            rpad        <= rpad_n;
            lscore      <= lscore_n;
            rscore      <= rscore_n;
            winner      <= winner_n;
            dx          <= dx_n;
            dy          <= dy_n;
            step        <= step_n;
            serve_cnt   <= serve_cnt_n;
            left_scored <= left_scored_n;
            vs_q        <= vSyncIn;
            start_q     <= startIn;
        end
    end

    always_comb begin
        state_n       = state;
        ball_x_n      = ball_x;
        ball_y_n      = ball_y;
        lpad_n        = lpad;
        rpad_n        = rpad;
        lscore_n      = lscore;
        rscore_n      = rscore;
        winner_n      = winner;
        dx_n          = dx;
        dy_n          = dy;
        step_n        = step;
        serve_cnt_n   = serve_cnt;
        left_scored_n = left_scored;
        y_mv          = ball_y;
        dy_mv         = dy;

        if (dy) begin
            if (ball_y + step > Y_MAX) begin
                y_mv  = Y_MAX;
                dy_mv = 1'b0;
            end else begin
                y_mv  = ball_y + step;
            end
        end else if (ball_y < step) begin
            y_mv  = 10'd0;
            dy_mv = 1'b1;
        end else begin
            y_mv  = ball_y - step;
        end

        if (tick && (state == SERVE || state == PLAY)) begin
            lpad_n = pad_move(lpad, lUpIn, lDnIn);
            rpad_n = pad_move(rpad, rUpIn, rDnIn);
        end

        case (state)
            IDLE, GAMEOVER: begin
                if (start_edge) begin
                    lscore_n    = 4'd0;
                    rscore_n    = 4'd0;
                    winner_n    = 2'd0;
                    ball_x_n    = X_CTR;
                    ball_y_n    = Y_CTR;
                    dx_n        = 1'b1;
                    dy_n        = 1'b1;
                    step_n      = STEP_INIT;
                    serve_cnt_n = 16'd0;
                    state_n     = SERVE;
                end
            end
            SERVE: begin
                if (tick) begin
                    if (serve_cnt == SERVE_LAST) state_n = PLAY;
                    else serve_cnt_n = serve_cnt + 16'd1;
                end
            end
            PLAY: begin
                if (tick) begin
                    if (l_miss || r_miss) begin
                        state_n       = POINT;
                        left_scored_n = r_miss;
                    end else begin
                        ball_y_n = y_mv;
                        dy_n     = dy_mv;
                        if (l_hit) begin
                            ball_x_n = L_EDGE;
                            dx_n     = 1'b1;
                            step_n   = step_hit;
                        end else if (r_hit) begin
                            ball_x_n = R_EDGE;
                            dx_n     = 1'b0;
                            step_n   = step_hit;
                        end else begin
                            ball_x_n = dx ? ball_x + step : ball_x - step;
                        end
                    end
                end
            end
            POINT: begin
                if (left_scored) lscore_n = score_inc;
                else rscore_n = score_inc;
                if (score_inc == WIN) begin
                    state_n  = GAMEOVER;
                    winner_n = left_scored ? 2'd1 : 2'd2;
                end else begin
                    // Serve toward the player who conceded.
                    ball_x_n    = X_CTR;
                    ball_y_n    = Y_CTR;
                    dx_n        = left_scored;
                    step_n      = STEP_INIT;
                    serve_cnt_n = 16'd0;
                    state_n     = SERVE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign vgaEnableOut = vga_en;
    assign ballXOut     = ball_x;
    assign ballYOut     = ball_y;
    assign lPadYOut     = lpad;
    assign rPadYOut     = rpad;
    assign lScoreOut    = lscore;
    assign rScoreOut    = rscore;
    assign stateOut     = state;
    assign winnerOut    = winner;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - directed self-checking bench for pong_game_ctrl
module tb_pong_game_ctrl;
    logic       clkIn = 1'b0;
    logic       rstIn, vSyncIn, startIn, lUpIn, lDnIn, rUpIn, rDnIn;
    logic       vgaEnableOut;
    logic [9:0] ballXOut, ballYOut, lPadYOut, rPadYOut;
    logic [3:0] lScoreOut, rScoreOut;
    logic [2:0] stateOut;
    logic [1:0] winnerOut;

    int n_cmp = 0;
    int n_bad = 0;

    pong_game_ctrl dut (
        .clkIn        (clkIn),
        .rstIn        (rstIn),
        .vSyncIn      (vSyncIn),
        .startIn      (startIn),
        .lUpIn        (lUpIn),
        .lDnIn        (lDnIn),
        .rUpIn        (rUpIn),
        .rDnIn        (rDnIn),
        .vgaEnableOut (vgaEnableOut),
        .ballXOut     (ballXOut),
        .ballYOut     (ballYOut),
        .lPadYOut     (lPadYOut),
        .rPadYOut     (rPadYOut),
        .lScoreOut    (lScoreOut),
        .rScoreOut    (rScoreOut),
        .stateOut     (stateOut),
        .winnerOut    (winnerOut)
    );

    always #5 clkIn = ~clkIn;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic step_clk();
        @(posedge clkIn);
        #1;
    endtask

    task automatic frame();
        vSyncIn = 1'b1;
        step_clk();
        vSyncIn = 1'b0;
        step_clk();
    endtask

    initial begin
        rstIn = 1'b0; vSyncIn = 1'b0; startIn = 1'b0;
        lUpIn = 1'b0; lDnIn = 1'b0; rUpIn = 1'b0; rDnIn = 1'b0;
        repeat (2) step_clk();
        expect_eq("rst_state", stateOut, 0);
        expect_eq("rst_en", vgaEnableOut, 0);
        expect_eq("rst_ball_x", ballXOut, 316);
        expect_eq("rst_ball_y", ballYOut, 236);
        expect_eq("rst_lpad", lPadYOut, 208);
        expect_eq("rst_rpad", rPadYOut, 208);
        expect_eq("rst_lscore", lScoreOut, 0);
        expect_eq("rst_rscore", rScoreOut, 0);
        expect_eq("rst_winner", winnerOut, 0);

        vSyncIn = 1'b1;
        rstIn   = 1'b1;
        #1;
        expect_eq("en_before_edge", vgaEnableOut, 0);
        step_clk();
        expect_eq("en_first_edge", vgaEnableOut, 1);
        vSyncIn = 1'b0;
        step_clk();

        repeat (5) frame();
        expect_eq("idle_state", stateOut, 0);
        expect_eq("idle_ball_x", ballXOut, 316);
        expect_eq("idle_ball_y", ballYOut, 236);

        startIn = 1'b1;
        step_clk();
        expect_eq("start_state", stateOut, 1);
        step_clk();
        startIn = 1'b0;

        // Serve: left paddle driven up to 0, right paddle down to 416.
        lUpIn = 1'b1; rDnIn = 1'b1;
        for (int t = 1; t <= 60; t++) begin
            frame();
            if (t == 1) begin
                expect_eq("serve1_state", stateOut, 1);
                expect_eq("serve1_lpad", lPadYOut, 204);
                expect_eq("serve1_rpad", rPadYOut, 212);
            end
            if (t == 59) begin
                expect_eq("serve59_state", stateOut, 1);
                expect_eq("lpad_clamp_top", lPadYOut, 0);
                expect_eq("rpad_clamp_bot", rPadYOut, 416);
            end
            if (t == 60) begin
                expect_eq("serve60_state", stateOut, 2);
                expect_eq("serve60_ball_x", ballXOut, 316);
                expect_eq("serve60_ball_y", ballYOut, 236);
            end
        end
        lUpIn = 1'b0; rDnIn = 1'b0;

        // Rally 1: bottom bounce, right paddle hit, top bounce, left paddle hit, left scores.
        for (int n = 1; n <= 742; n++) begin
            lDnIn = ((n >= 147) && (n <= 260)) || ((n >= 337) && (n <= 345));
            lUpIn = (n >= 261) && (n <= 345);
            frame();
            case (n)
                1: begin
                    expect_eq("move1_x", ballXOut, 318);
                    expect_eq("move1_y", ballYOut, 238);
                end
                118: expect_eq("n118_y", ballYOut, 472);
                119: expect_eq("bottom_clamp_y", ballYOut, 472);
                120: begin
                    expect_eq("bottom_bounce_y", ballYOut, 470);
                    expect_eq("n120_x", ballXOut, 556);
                end
                146: begin
                    expect_eq("rhit_x", ballXOut, 608);
                    expect_eq("rhit_y", ballYOut, 418);
                end
                147: expect_eq("after_rhit_x", ballXOut, 606);
                260: expect_eq("lpad_clamp_416", lPadYOut, 416);
                336: expect_eq("lpad_up_112", lPadYOut, 112);
                345: expect_eq("lpad_both_hold", lPadYOut, 112);
                355: expect_eq("top_y_0", ballYOut, 0);
                356: expect_eq("top_clamp_y", ballYOut, 0);
                357: begin
                    expect_eq("top_bounce_y", ballYOut, 2);
                    expect_eq("n357_x", ballXOut, 186);
                end
                438: begin
                    expect_eq("lhit_x", ballXOut, 24);
                    expect_eq("lhit_y", ballYOut, 164);
                end
                439: expect_eq("after_lhit_x", ballXOut, 26);
                742: begin
                    expect_eq("pre_miss_x", ballXOut, 632);
                    expect_eq("pre_miss_y", ballYOut, 174);
                    expect_eq("pre_miss_state", stateOut, 2);
                end
                default: ;
            endcase
        end
        lDnIn = 1'b0; lUpIn = 1'b0;

        vSyncIn = 1'b1;
        step_clk();
        expect_eq("point1_state", stateOut, 3);
        expect_eq("point1_frozen_x", ballXOut, 632);
        vSyncIn = 1'b0;
        step_clk();
        expect_eq("point1_next_state", stateOut, 1);
        expect_eq("point1_lscore", lScoreOut, 1);
        expect_eq("point1_rscore", rScoreOut, 0);
        expect_eq("point1_ball_x", ballXOut, 316);
        expect_eq("point1_ball_y", ballYOut, 236);
        expect_eq("point1_winner", winnerOut, 0);

        // Rallies 2..7: right paddle parked at 176, every serve goes right and misses.
        for (int r = 2; r <= 7; r++) begin
            rUpIn = (r == 2);
            repeat (60) frame();
            rUpIn = 1'b0;
            expect_eq("rally_play_state", stateOut, 2);
            if (r == 2) expect_eq("rpad_176", rPadYOut, 176);
            repeat (158) frame();
            vSyncIn = 1'b1;
            step_clk();
            expect_eq("rally_point_state", stateOut, 3);
            vSyncIn = 1'b0;
            step_clk();
            expect_eq("rally_lscore", lScoreOut, r);
            expect_eq("rally_next_state", stateOut, (r == 7) ? 4 : 1);
            expect_eq("rally_winner", winnerOut, (r == 7) ? 1 : 0);
        end
        expect_eq("final_rscore", rScoreOut, 0);

        startIn = 1'b1;
        step_clk();
        expect_eq("restart_state", stateOut, 1);
        expect_eq("restart_lscore", lScoreOut, 0);
        expect_eq("restart_winner", winnerOut, 0);
        expect_eq("restart_ball_x", ballXOut, 316);
        startIn = 1'b0;
        step_clk();

        repeat (3) frame();
        #2;
        rstIn = 1'b0;
        #1;
        expect_eq("async_rst_state", stateOut, 0);
        expect_eq("async_rst_en", vgaEnableOut, 0);
        expect_eq("async_rst_lpad", lPadYOut, 208);
        expect_eq("async_rst_rpad", rPadYOut, 176 + 32);

        startIn = 1'b1;
        step_clk();
        rstIn = 1'b1;
        repeat (3) step_clk();
        expect_eq("held_start_no_trigger", stateOut, 0);
        startIn = 1'b0;
        step_clk();
        startIn = 1'b1;
        step_clk();
        expect_eq("fresh_start_state", stateOut, 1);
        startIn = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
